div_job_sequencer: RTL and testbench

DIV_JOB_SEQUENCER -- requirements
Module: div_job_sequencer

---
 rtl/div_job_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_div_job_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_job_sequencer.sv
//------------------------------------------------------------------------------
// div_job_sequencer
//
// Purpose:
//    Queues division jobs in a small FIFO and feeds them one at a time to an
//    external iterative divider. For each job it pulses a divider clear,
//    issues a start, waits for done or error, then holds the result on a
//    valid/ready output port until the consumer takes it.
//
// Optional feature:
//    DIV_TIMEOUT_EN - when defined, adds parameter 'timeout' and a watchdog
//                     counter. A job that gets no done/error within
//                     'timeout' cycles of being issued is retired with
//                     out_error=1 and a zero payload.
//
// Ports:
//    clk, rst                        single clock, synchronous active-high reset
//    in_valid / in_ready             upstream job handshake
//    in_dividend, in_divisor         job operands (width bits)
//    in_signed                       job is a signed division
//    out_valid / out_ready           downstream result handshake
//    out_quotient, out_remainder     result payload (width bits)
//    out_error                       job ended in a divider error or timeout
//    div_rst, div_start              divider clear and start strobes
//    div_signed_op                   divider signed-mode select
//    div_dividend, div_divisor       divider operands
//    div_quotient, div_remainder     divider results
//    div_done, div_error, div_busy   divider status
//------------------------------------------------------------------------------
module div_job_sequencer #(
   parameter int width = 8,
   parameter int depth = 4
`ifdef DIV_TIMEOUT_EN
   ,
   parameter int timeout = 64
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_dividend,
   input  logic [width-1:0] in_divisor,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_quotient,
   output logic [width-1:0] out_remainder,
   output logic             out_error,
   output logic             div_rst,
   output logic             div_start,
   output logic             div_signed_op,
   output logic [width-1:0] div_dividend,
   output logic [width-1:0] div_divisor,
   input  logic [width-1:0] div_quotient,
   input  logic [width-1:0] div_remainder,
   input  logic             div_done,
   input  logic             div_error,
   input  logic             div_busy
);

   localparam int aw = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [aw:0] full_count = (aw+1)'(depth);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ISSUE,
      WAIT,
      OUTPUT
   } state_t;

   state_t state, state_next;

   logic [width-1:0] mem_dividend [depth];
   logic [width-1:0] mem_divisor  [depth];
   logic             mem_signed   [depth];

   logic [aw-1:0] wr_ptr, rd_ptr;
   logic [aw:0]   count;
   logic          full, empty, push, pop;

   logic [width-1:0] op_dividend, op_divisor;
   logic             op_signed;

   logic capture, timed_out, to_expired;

   assign full     = (count == full_count);
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;

   assign out_valid     = (state == OUTPUT);
   assign div_start     = (state == ISSUE);
   assign div_rst       = rst || (state == CLEAR);
   assign div_dividend  = op_dividend;
   assign div_divisor   = op_divisor;
   assign div_signed_op = op_signed;

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_dividend[wr_ptr] <= in_dividend;
         mem_divisor[wr_ptr]  <= in_divisor;
         mem_signed[wr_ptr]   <= in_signed;
      end
   end

   // Pointers wrap naturally because depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The popped head entry is held here so the divider operands stay put
   // while the FIFO keeps accepting new jobs.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_dividend <= '0;
         op_divisor  <= '0;
         op_signed   <= 1'b0;
      end else if (pop) begin
         op_dividend <= mem_dividend[rd_ptr];
         op_divisor  <= mem_divisor[rd_ptr];
         op_signed   <= mem_signed[rd_ptr];
      end
   end

`ifdef DIV_TIMEOUT_EN
   localparam int tw = $clog2(timeout + 1);
   localparam logic [tw-1:0] to_last = tw'(timeout - 1);

   logic [tw-1:0] to_cnt;

   // Cleared while in CLEAR so it reads zero on the first ISSUE cycle; the
   // job is retired on the edge after it reaches timeout-1.
   always_ff @(posedge clk) begin
      if (rst || state == CLEAR) begin
         to_cnt <= '0;
      end else if ((state == ISSUE || state == WAIT) && to_cnt != to_last) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign to_expired = (to_cnt == to_last);
`else
   assign to_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A real divider response wins over a timeout that expires in the same cycle.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      capture    = 1'b0;
      timed_out  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            state_next = ISSUE;
         end
         ISSUE: begin
            if (div_done || div_error) begin
               capture    = 1'b1;
               state_next = OUTPUT;
            end else if (to_expired) begin
               capture    = 1'b1;
               timed_out  = 1'b1;
               state_next = OUTPUT;
            end else if (div_busy) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (div_done || div_error) begin
               capture    = 1'b1;
               state_next = OUTPUT;
            end else if (to_expired) begin
               capture    = 1'b1;
               timed_out  = 1'b1;
               state_next = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_ready) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The payload is captured once on entry to OUTPUT and held until taken;
   // the divider's result bits are meaningless on an error, so they are zeroed.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_quotient  <= '0;
         out_remainder <= '0;
         out_error     <= 1'b0;
      end else if (capture) begin
         if (timed_out || div_error) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_error     <= 1'b1;
         end else begin
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
            out_error     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_job_sequencer.sv
//------------------------------------------------------------------------------
// tb_div_job_sequencer
//
// Purpose:
//    Testbench for div_job_sequencer. A behavioural divider stands in for the
//    real one; expected results are computed from each job's operands when it
//    is pushed and kept in order in a queue.
//
// Ports: none (top-level bench).
//------------------------------------------------------------------------------
module tb_div_job_sequencer;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_signed;
   logic [W-1:0] in_dividend, in_divisor;
   logic         out_valid, out_ready, out_error;
   logic [W-1:0] out_quotient, out_remainder;
   logic         div_rst, div_start, div_signed_op;
   logic [W-1:0] div_dividend, div_divisor;
   logic [W-1:0] div_quotient, div_remainder;
   logic         div_done, div_error, div_busy;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         e;
   } res_t;

   res_t expq[$];
   res_t last_res;
   res_t mon_exp;
   res_t stub_res;
   int   checks = 0;
   int   errors = 0;
   int   results = 0;
   int   cyc = 0;

   int           lat_override = -1;
   bit           hang = 1'b0;
   bit           rand_ready = 1'b0;
   bit           stub_active = 1'b0;
   bit           stub_hold = 1'b0;
   int           stub_cnt = 0;
   int           stub_lat = 0;
   logic [W-1:0] stub_a, stub_b;
   logic         stub_s;

   div_job_sequencer #(
      .width(W),
      .depth(D)
`ifdef DIV_TIMEOUT_EN
      ,
      .timeout(16)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_dividend(in_dividend),
      .in_divisor(in_divisor),
      .in_signed(in_signed),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_quotient(out_quotient),
      .out_remainder(out_remainder),
      .out_error(out_error),
      .div_rst(div_rst),
      .div_start(div_start),
      .div_signed_op(div_signed_op),
      .div_dividend(div_dividend),
      .div_divisor(div_divisor),
      .div_quotient(div_quotient),
      .div_remainder(div_remainder),
      .div_done(div_done),
      .div_error(div_error),
      .div_busy(div_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Truncating division, remainder takes the dividend's sign; x/0 is an error.
   function automatic res_t refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      res_t x;
      int   na, nb, qq, rr;
      x = '0;
      if (b == '0) begin
         x.e = 1'b1;
      end else if (s) begin
         na = int'($signed(a));
         nb = int'($signed(b));
         qq = na / nb;
         rr = na % nb;
         x.q = qq[W-1:0];
         x.r = rr[W-1:0];
      end else begin
         x.q = a / b;
         x.r = a % b;
      end
      return x;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Error responses carry junk result bits so the zeroing is exercised.
   task automatic stubFinish(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      stub_res = refDiv(a, b, s);
      if (stub_res.e) begin
         div_error     <= 1'b1;
         div_quotient  <= 8'hA5;
         div_remainder <= 8'h5A;
      end else begin
         div_done      <= 1'b1;
         div_quotient  <= stub_res.q;
         div_remainder <= stub_res.r;
      end
      stub_hold <= 1'b1;
   endtask

   // Divider stand-in: latency 0 answers straight from ISSUE without busy,
   // otherwise busy is raised first so the WAIT path is used.
   always @(posedge clk) begin
      if (div_rst) begin
         stub_active <= 1'b0;
         stub_hold   <= 1'b0;
         div_busy    <= 1'b0;
         div_done    <= 1'b0;
         div_error   <= 1'b0;
      end else begin
         div_done  <= 1'b0;
         div_error <= 1'b0;
         if (stub_hold && !div_start) stub_hold <= 1'b0;
         if (stub_active) begin
            if (stub_cnt == 0) begin
               stub_active <= 1'b0;
               div_busy    <= 1'b0;
               stubFinish(stub_a, stub_b, stub_s);
            end else begin
               stub_cnt <= stub_cnt - 1;
            end
         end else if (div_start && !stub_hold && !hang) begin
            stub_lat = (lat_override >= 0) ? lat_override : int'($urandom_range(0, 4));
            if (stub_lat == 0) begin
               stubFinish(div_dividend, div_divisor, div_signed_op);
            end else begin
               stub_active <= 1'b1;
               stub_cnt    <= stub_lat - 1;
               div_busy    <= 1'b1;
               stub_a      <= div_dividend;
               stub_b      <= div_divisor;
               stub_s      <= div_signed_op;
            end
         end
      end
   end

   // Scoreboard: every accepted result must match the oldest outstanding job.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         results++;
         last_res = '{out_quotient, out_remainder, out_error};
         if (expq.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_exp = expq.pop_front();
            checkOutput("quot", 32'(out_quotient), 32'(mon_exp.q));
            checkOutput("rem", 32'(out_remainder), 32'(mon_exp.r));
            checkOutput("err", 32'(out_error), 32'(mon_exp.e));
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int g = 0;
      in_valid    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
      in_signed   = s;
      @(negedge clk);
      while (!in_ready && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) checkOutput("push_timeout", 32'd0, 32'd1);
      else expq.push_back(refDiv(a, b, s));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitResults(input int target, input string tag);
      int g = 0;
      while (results < target && g < 2000) begin
         @(posedge clk);
         g++;
      end
      checkOutput(tag, 32'(results >= target), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic waitOutValid(input string tag);
      int g = 0;
      @(negedge clk);
      while (!out_valid && g < 2000) begin
         @(negedge clk);
         g++;
      end
      checkOutput(tag, 32'(out_valid), 32'd1);
   endtask

   int base;
   int t0, t1, g;

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_dividend = '0;
      in_divisor  = '0;
      in_signed   = 1'b0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_div_rst", 32'(div_rst), 32'd1);
      checkOutput("rst_div_start", 32'(div_start), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_div_rst_off", 32'(div_rst), 32'd0);
      checkOutput("rst_quot", 32'(out_quotient), 32'd0);
      checkOutput("rst_rem", 32'(out_remainder), 32'd0);
      checkOutput("rst_err", 32'(out_error), 32'd0);
      checkOutput("rst_operand", 32'(div_dividend), 32'd0);
      @(posedge clk);
      #1;

      // Directed jobs with hand-derived answers.
      out_ready = 1'b1;
      applyStimulus(8'd100, 8'd7, 1'b0);
      waitResults(1, "res_100_7");
      checkOutput("q_100_7", 32'(last_res.q), 32'd14);
      checkOutput("r_100_7", 32'(last_res.r), 32'd2);
      checkOutput("e_100_7", 32'(last_res.e), 32'd0);

      applyStimulus(8'd25, 8'd0, 1'b0);
      waitResults(2, "res_25_0");
      checkOutput("q_div0", 32'(last_res.q), 32'd0);
      checkOutput("r_div0", 32'(last_res.r), 32'd0);
      checkOutput("e_div0", 32'(last_res.e), 32'd1);

      applyStimulus(8'd50, 8'd5, 1'b0);
      waitResults(3, "res_50_5");
      checkOutput("q_after_err", 32'(last_res.q), 32'd10);
      checkOutput("r_after_err", 32'(last_res.r), 32'd0);

      // -100 / 7 signed = -14 rem -2
      applyStimulus(8'h9C, 8'd7, 1'b1);
      waitResults(4, "res_signed");
      checkOutput("q_signed", 32'(last_res.q), 32'hF2);
      checkOutput("r_signed", 32'(last_res.r), 32'hFE);

      // Five jobs with the consumer stalled: one in flight, four fill the FIFO.
      out_ready = 1'b0;
      base = results;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(W'($urandom), W'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      waitResults(base + 5, "full_drain");

      // Line a push up with the IDLE pop while two jobs sit in the FIFO.
      out_ready = 1'b0;
      base = results;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(W'($urandom), W'($urandom_range(1, 255)), 1'b0);
      end
      waitOutValid("pp_first_valid");
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      applyStimulus(W'($urandom), W'($urandom_range(1, 255)), 1'b0);
      applyStimulus(W'($urandom), W'($urandom_range(1, 255)), 1'b0);
      @(negedge clk);
      checkOutput("pp_count3_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      applyStimulus(W'($urandom), W'($urandom_range(1, 255)), 1'b0);
      @(negedge clk);
      checkOutput("pp_count4_full", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      waitResults(base + 6, "pp_drain");

      // Reset while the divider is busy with three jobs waiting behind it.
      lat_override = 20;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(W'($urandom), W'($urandom_range(1, 255)), 1'b0);
      end
      g = 0;
      @(negedge clk);
      while (!(div_busy && !div_start) && g < 200) begin
         @(negedge clk);
         g++;
      end
      checkOutput("rst_mid_wait", 32'(div_busy && !div_start), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      expq.delete();
      @(negedge clk);
      checkOutput("rst_mid_div_rst", 32'(div_rst), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      base = results;
      lat_override = -1;
      @(negedge clk);
      checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
      repeat (40) @(posedge clk);
      checkOutput("rst_mid_no_stale", 32'(results), 32'(base));
      #1;

      // Random jobs, random divider latency, random consumer back-pressure.
      base = results;
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(W'($urandom),
                       ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom),
                       1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      waitResults(base + 40, "rand_drain");

`ifdef DIV_TIMEOUT_EN
      // Divider never answers: job must be retired 16 cycles after ISSUE entry.
      hang = 1'b1;
      base = results;
      applyStimulus(8'd9, 8'd3, 1'b0);
      expq[expq.size()-1] = '{'0, '0, 1'b1};
      g = 0;
      while (!div_start && g < 100) begin
         @(negedge clk);
         g++;
      end
      t0 = cyc;
      g = 0;
      while (!out_valid && g < 200) begin
         @(negedge clk);
         g++;
      end
      t1 = cyc;
      checkOutput("timeout_cycles", 32'(t1 - t0), 32'd16);
      checkOutput("timeout_err", 32'(out_error), 32'd1);
      waitResults(base + 1, "timeout_res");
      hang = 1'b0;
`endif

      checkOutput("all_results_seen", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
